// File: rtl/ysyx_23060236_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060236_axi_rd_arbiter
// Brief    : Round-robin IFU/LSU arbiter onto one AXI4 read master port,
//            one transaction in flight, R channel routed back to the owner.
// Revision : 1.0
// ============================================================================
module ysyx_23060236_axi_rd_arbiter #(
    parameter logic [3:0] IFU_ID = 4'h0,
    parameter logic [3:0] LSU_ID = 4'h1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    input  logic [1:0]  ifu_arburst,
    input  logic [3:0]  ifu_arlen,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rlast,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,

    input  logic [31:0] lsu_araddr,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    input  logic [2:0]  lsu_arsize,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,

    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [3:0]  m_arid,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [3:0]  m_rid,

    output logic [31:0] contend_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic c_IFU = 1'b0;
    localparam logic c_LSU = 1'b1;

    state_t      r_state;
    logic        r_last_grant;
    logic        r_owner;
    logic [31:0] r_araddr;
    logic [3:0]  r_arid;
    logic [7:0]  r_arlen;
    logic [2:0]  r_arsize;
    logic [1:0]  r_arburst;
    logic [31:0] r_contend_cnt;

    logic w_idle;
    logic w_grant_ifu;
    logic w_grant_lsu;
    logic w_route_ifu;
    logic w_route_lsu;
    logic w_last_fire;
    logic w_unused;

    // Grants are suppressed while reset is held so no handshake escapes.
    assign w_idle      = (r_state == S_IDLE) & ~reset;
    assign w_grant_lsu = w_idle & lsu_arvalid & (~ifu_arvalid | (r_last_grant == c_IFU));
    assign w_grant_ifu = w_idle & ifu_arvalid & ~w_grant_lsu;

    assign w_route_ifu = (r_state == S_DATA) & (r_owner == c_IFU);
    assign w_route_lsu = (r_state == S_DATA) & (r_owner == c_LSU);
    assign w_last_fire = m_rvalid & m_rready & m_rlast;

    // Only one transaction is ever outstanding, so the returned ID carries no information.
    assign w_unused = ^m_rid;

    assign ifu_arready = w_grant_ifu;
    assign lsu_arready = w_grant_lsu;

    assign m_arvalid = (r_state == S_ADDR);
    assign m_araddr  = r_araddr;
    assign m_arid    = r_arid;
    assign m_arlen   = r_arlen;
    assign m_arsize  = r_arsize;
    assign m_arburst = r_arburst;

    assign m_rready   = (w_route_ifu & ifu_rready) | (w_route_lsu & lsu_rready);
    assign ifu_rvalid = w_route_ifu & m_rvalid;
    assign ifu_rdata  = w_route_ifu ? m_rdata : 32'd0;
    assign ifu_rresp  = w_route_ifu ? m_rresp : 2'd0;
    assign ifu_rlast  = w_route_ifu & m_rlast;
    assign lsu_rvalid = w_route_lsu & m_rvalid;
    assign lsu_rdata  = w_route_lsu ? m_rdata : 32'd0;
    assign lsu_rresp  = w_route_lsu ? m_rresp : 2'd0;

    assign contend_cnt = r_contend_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_last_grant  <= c_IFU;
            r_owner       <= c_IFU;
            r_araddr      <= 32'd0;
            r_arid        <= 4'd0;
            r_arlen       <= 8'd0;
            r_arsize      <= 3'd0;
            r_arburst     <= 2'd0;
            r_contend_cnt <= 32'd0;
        end else begin
            if ((ifu_arvalid & ~w_grant_ifu) | (lsu_arvalid & ~w_grant_lsu)) begin
                r_contend_cnt <= r_contend_cnt + 32'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_grant_ifu) begin
                        r_state      <= S_ADDR;
                        r_owner      <= c_IFU;
                        r_last_grant <= c_IFU;
                        r_araddr     <= ifu_araddr;
                        r_arid       <= IFU_ID;
                        r_arlen      <= {4'b0000, ifu_arlen};
                        r_arsize     <= 3'b010;
                        r_arburst    <= ifu_arburst;
                    end else if (w_grant_lsu) begin
                        r_state      <= S_ADDR;
                        r_owner      <= c_LSU;
                        r_last_grant <= c_LSU;
                        r_araddr     <= lsu_araddr;
                        r_arid       <= LSU_ID;
                        r_arlen      <= 8'd0;
                        r_arsize     <= lsu_arsize;
                        r_arburst    <= 2'b01;
                    end
                end
                S_ADDR: begin
                    if (m_arready) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_last_fire) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060236_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060236_axi_rd_arbiter
// Brief    : Directed scenarios plus a randomized run against a
//            transaction-level model of the read arbiter.
// Revision : 1.0
// ============================================================================
module tb_ysyx_23060236_axi_rd_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic        ifu_arready;
    logic [1:0]  ifu_arburst;
    logic [3:0]  ifu_arlen;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rlast;
    logic        ifu_rvalid;
    logic        ifu_rready;
    logic [31:0] lsu_araddr;
    logic        lsu_arvalid;
    logic        lsu_arready;
    logic [2:0]  lsu_arsize;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rvalid;
    logic        lsu_rready;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [3:0]  m_arid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready;
    logic [3:0]  m_rid;
    logic [31:0] contend_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    ysyx_23060236_axi_rd_arbiter dut (
        .clock(clock), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_arburst(ifu_arburst), .ifu_arlen(ifu_arlen),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_arsize(lsu_arsize),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready), .m_rid(m_rid),
        .contend_cnt(contend_cnt)
    );

    always #5 clock = ~clock;

    // Inputs change 1 ns after a rising edge; outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic clear_inputs();
        ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_arburst = '0; ifu_arlen = '0; ifu_rready = 1'b0;
        lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_arsize = '0; lsu_rready = 1'b0;
        m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0; m_rid = '0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        ifu_arvalid = 1'b1; lsu_arvalid = 1'b1; m_rvalid = 1'b1;
        tick(); settle();
        n_checks++; if (ifu_arready !== 1'b0) $display("FAIL rst_ifu_arready got=%b want=0", ifu_arready); else n_pass++;
        n_checks++; if (lsu_arready !== 1'b0) $display("FAIL rst_lsu_arready got=%b want=0", lsu_arready); else n_pass++;
        n_checks++; if (m_arvalid !== 1'b0) $display("FAIL rst_m_arvalid got=%b want=0", m_arvalid); else n_pass++;
        n_checks++; if (m_rready !== 1'b0) $display("FAIL rst_m_rready got=%b want=0", m_rready); else n_pass++;
        n_checks++; if (ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0) $display("FAIL rst_rvalid got=%b%b want=00", ifu_rvalid, lsu_rvalid); else n_pass++;
        n_checks++; if (m_araddr !== 32'd0) $display("FAIL rst_m_araddr got=%h want=0", m_araddr); else n_pass++;
        n_checks++; if ({m_arid, m_arlen, m_arsize, m_arburst} !== 17'd0) $display("FAIL rst_m_ar_fields got=%h want=0", {m_arid, m_arlen, m_arsize, m_arburst}); else n_pass++;
        n_checks++; if (contend_cnt !== 32'd0) $display("FAIL rst_contend got=%0d want=0", contend_cnt); else n_pass++;
        tick();
        clear_inputs();
        reset = 1'b0;
        settle();
        n_checks++; if (m_arvalid !== 1'b0) $display("FAIL rst_idle_arvalid got=%b want=0", m_arvalid); else n_pass++;
        n_checks++; if (contend_cnt !== 32'd0) $display("FAIL rst_contend_after got=%0d want=0", contend_cnt); else n_pass++;
    endtask

    task automatic test_lsu_read();
        logic [31:0] d;
        reset_dut();
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0010; lsu_arsize = 3'b010;
        settle();
        n_checks++; if (lsu_arready !== 1'b1) $display("FAIL lsu_arready got=%b want=1", lsu_arready); else n_pass++;
        n_checks++; if (ifu_arready !== 1'b0) $display("FAIL lsu_ifu_arready got=%b want=0", ifu_arready); else n_pass++;
        n_checks++; if (m_arvalid !== 1'b0) $display("FAIL lsu_arvalid_early got=%b want=0", m_arvalid); else n_pass++;
        tick();
        lsu_arvalid = 1'b0; m_arready = 1'b1;
        settle();
        n_checks++; if (m_arvalid !== 1'b1) $display("FAIL lsu_m_arvalid got=%b want=1", m_arvalid); else n_pass++;
        n_checks++; if (m_araddr !== 32'h8000_0010) $display("FAIL lsu_m_araddr got=%h want=80000010", m_araddr); else n_pass++;
        n_checks++; if (m_arlen !== 8'd0 || m_arid !== 4'h1) $display("FAIL lsu_len_id got=%h/%h want=0/1", m_arlen, m_arid); else n_pass++;
        n_checks++; if (m_arsize !== 3'b010 || m_arburst !== 2'b01) $display("FAIL lsu_size_burst got=%b/%b want=010/01", m_arsize, m_arburst); else n_pass++;
        tick();
        d = $urandom;
        m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = d; m_rlast = 1'b1; m_rresp = 2'b00; m_rid = 4'hF;
        lsu_rready = 1'b1; ifu_rready = 1'b1;
        settle();
        n_checks++; if (lsu_rvalid !== 1'b1) $display("FAIL lsu_rvalid got=%b want=1", lsu_rvalid); else n_pass++;
        n_checks++; if (lsu_rdata !== d) $display("FAIL lsu_rdata got=%h want=%h", lsu_rdata, d); else n_pass++;
        n_checks++; if (ifu_rvalid !== 1'b0) $display("FAIL lsu_ifu_rvalid got=%b want=0", ifu_rvalid); else n_pass++;
        n_checks++; if (m_rready !== 1'b1) $display("FAIL lsu_m_rready got=%b want=1", m_rready); else n_pass++;
        tick();
        settle();
        n_checks++; if (m_rready !== 1'b0 || lsu_rvalid !== 1'b0) $display("FAIL lsu_after_last got=%b%b want=00", m_rready, lsu_rvalid); else n_pass++;
    endtask

    task automatic test_ifu_burst_stall();
        int got   = 0;
        int stall = 0;
        reset_dut();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0040; ifu_arlen = 4'd7; ifu_arburst = 2'b01;
        settle();
        n_checks++; if (ifu_arready !== 1'b1 || lsu_arready !== 1'b0) $display("FAIL ifu_grant got=%b%b want=10", ifu_arready, lsu_arready); else n_pass++;
        tick();
        ifu_arvalid = 1'b0; m_arready = 1'b1;
        settle();
        n_checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h3000_0040) $display("FAIL ifu_ar got=%b/%h want=1/30000040", m_arvalid, m_araddr); else n_pass++;
        n_checks++; if (m_arlen !== 8'd7 || m_arid !== 4'h0) $display("FAIL ifu_len_id got=%h/%h want=07/0", m_arlen, m_arid); else n_pass++;
        n_checks++; if (m_arsize !== 3'b010 || m_arburst !== 2'b01) $display("FAIL ifu_size_burst got=%b/%b want=010/01", m_arsize, m_arburst); else n_pass++;
        tick();
        m_arready = 1'b0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            m_rvalid = 1'b1; m_rdata = 32'hA500_0000 + 32'(got); m_rlast = (got == 7);
            ifu_rready = !(got == 3 && stall < 3);
            settle();
            if (!ifu_rready) begin
                stall++;
                n_checks++; if (m_rready !== 1'b0) $display("FAIL ifu_stall_m_rready beat=%0d got=%b want=0", got, m_rready); else n_pass++;
            end else begin
                n_checks++; if (ifu_rvalid !== 1'b1 || m_rready !== 1'b1) $display("FAIL ifu_beat_valid beat=%0d got=%b%b want=11", got, ifu_rvalid, m_rready); else n_pass++;
                n_checks++; if (ifu_rdata !== 32'hA500_0000 + 32'(got)) $display("FAIL ifu_beat_data beat=%0d got=%h want=%h", got, ifu_rdata, 32'hA500_0000 + 32'(got)); else n_pass++;
                n_checks++; if (ifu_rlast !== (got == 7)) $display("FAIL ifu_beat_rlast beat=%0d got=%b want=%b", got, ifu_rlast, (got == 7)); else n_pass++;
                got++;
            end
            tick();
        end
        // Back-to-back: the cycle after the last beat is IDLE and can grant again.
        m_rlast = 1'b1; lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0100;
        settle();
        n_checks++; if (ifu_rvalid !== 1'b0 || m_rready !== 1'b0) $display("FAIL ifu_post_burst got=%b%b want=00", ifu_rvalid, m_rready); else n_pass++;
        n_checks++; if (lsu_arready !== 1'b1) $display("FAIL back_to_back_grant got=%b want=1", lsu_arready); else n_pass++;
    endtask

    task automatic test_tie_contend();
        int k      = $urandom_range(0, 3);
        int w      = $urandom_range(0, 3);
        int waited = 0;
        reset_dut();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h1000_0000; ifu_arlen = 4'd0; ifu_arburst = 2'b01;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h2000_0004; lsu_arsize = 3'b010; lsu_rready = 1'b1;
        settle();
        n_checks++; if (lsu_arready !== 1'b1 || ifu_arready !== 1'b0) $display("FAIL tie_first got lsu/ifu=%b%b want=10", lsu_arready, ifu_arready); else n_pass++;
        waited++;
        tick();
        lsu_arvalid = 1'b0;
        for (int i = 0; i <= k; i++) begin
            m_arready = (i == k);
            settle();
            n_checks++; if (ifu_arready !== 1'b0) $display("FAIL tie_ifu_wait_addr i=%0d got=%b want=0", i, ifu_arready); else n_pass++;
            waited++;
            tick();
        end
        m_arready = 1'b0;
        for (int i = 0; i <= w; i++) begin
            m_rvalid = (i == w); m_rlast = 1'b1; m_rdata = $urandom;
            settle();
            n_checks++; if (ifu_arready !== 1'b0) $display("FAIL tie_ifu_wait_data i=%0d got=%b want=0", i, ifu_arready); else n_pass++;
            waited++;
            tick();
        end
        m_rvalid = 1'b0;
        settle();
        n_checks++; if (ifu_arready !== 1'b1) $display("FAIL tie_ifu_second got=%b want=1", ifu_arready); else n_pass++;
        n_checks++; if (contend_cnt !== 32'(waited)) $display("FAIL tie_contend got=%0d want=%0d", contend_cnt, waited); else n_pass++;
        tick();
        ifu_arvalid = 1'b0;
        settle();
        n_checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h1000_0000) $display("FAIL tie_ifu_ar got=%b/%h want=1/10000000", m_arvalid, m_araddr); else n_pass++;
    endtask

    task automatic test_alternate();
        logic        exp_lsu = 1'b1;
        int          total   = 0;
        int          nb;
        logic [31:0] held;
        reset_dut();
        ifu_arvalid = 1'b1; ifu_araddr = $urandom; ifu_arlen = 4'd1; ifu_arburst = 2'b01;
        lsu_arvalid = 1'b1; lsu_araddr = $urandom; lsu_arsize = 3'b010;
        m_arready = 1'b1; ifu_rready = 1'b1; lsu_rready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            m_rvalid = 1'b0;
            held = exp_lsu ? lsu_araddr : ifu_araddr;
            settle();
            n_checks++; if (lsu_arready !== exp_lsu || ifu_arready !== !exp_lsu) $display("FAIL alt_grant t=%0d got lsu/ifu=%b%b want lsu=%b", t, lsu_arready, ifu_arready, exp_lsu); else n_pass++;
            total++;
            tick();
            // The winner immediately presents its next request with a new address.
            if (exp_lsu) lsu_araddr = $urandom; else ifu_araddr = $urandom;
            settle();
            n_checks++; if (m_arid !== (exp_lsu ? 4'h1 : 4'h0) || m_araddr !== held) $display("FAIL alt_ar t=%0d got=%h/%h want=%h/%h", t, m_arid, m_araddr, (exp_lsu ? 4'h1 : 4'h0), held); else n_pass++;
            total++;
            tick();
            nb = exp_lsu ? 1 : 2;
            for (int b = 0; b < nb; b++) begin
                m_rvalid = 1'b1; m_rlast = (b == nb - 1); m_rdata = $urandom;
                settle();
                n_checks++; if ((exp_lsu ? lsu_rvalid : ifu_rvalid) !== 1'b1) $display("FAIL alt_beat t=%0d b=%0d got=%b want=1", t, b, exp_lsu ? lsu_rvalid : ifu_rvalid); else n_pass++;
                total++;
                tick();
            end
            exp_lsu = !exp_lsu;
        end
        m_rvalid = 1'b0;
        settle();
        n_checks++; if (contend_cnt !== 32'(total)) $display("FAIL alt_contend got=%0d want=%0d", contend_cnt, total); else n_pass++;
    endtask

    task automatic test_reset_mid_data();
        reset_dut();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0080; ifu_arlen = 4'd7; ifu_arburst = 2'b01;
        ifu_rready = 1'b1; m_arready = 1'b1;
        tick();
        ifu_arvalid = 1'b0;
        tick();
        for (int b = 0; b < 3; b++) begin
            m_rvalid = 1'b1; m_rlast = 1'b0; m_rdata = $urandom;
            tick();
        end
        m_rvalid = 1'b1; m_rlast = 1'b0; m_rdata = 32'hDEAD_BEEF;
        reset = 1'b1;
        #1;
        n_checks++; if (ifu_rvalid !== 1'b0 || m_rready !== 1'b0) $display("FAIL mid_rst_r got=%b%b want=00", ifu_rvalid, m_rready); else n_pass++;
        n_checks++; if (m_arvalid !== 1'b0 || m_araddr !== 32'd0 || m_arlen !== 8'd0) $display("FAIL mid_rst_ar got=%b/%h/%h want=0/0/0", m_arvalid, m_araddr, m_arlen); else n_pass++;
        n_checks++; if (ifu_rdata !== 32'd0) $display("FAIL mid_rst_rdata got=%h want=0", ifu_rdata); else n_pass++;
        tick();
        reset = 1'b0;
        settle();
        n_checks++; if (ifu_rvalid !== 1'b0 || m_rready !== 1'b0) $display("FAIL post_rst_r got=%b%b want=00", ifu_rvalid, m_rready); else n_pass++;
        tick();
        m_rvalid = 1'b0; lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0020; lsu_arsize = 3'b001;
        settle();
        n_checks++; if (lsu_arready !== 1'b1) $display("FAIL post_rst_grant got=%b want=1", lsu_arready); else n_pass++;
        tick();
        lsu_arvalid = 1'b0;
        settle();
        n_checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h8000_0020 || m_arid !== 4'h1) $display("FAIL post_rst_ar got=%b/%h/%h want=1/80000020/1", m_arvalid, m_araddr, m_arid); else n_pass++;
    endtask

    // Transaction-level model: at most one read in flight, round-robin on ties,
    // beats delivered only to the owner, contention counted per cycle.
    task automatic test_random();
        bit          busy = 0, in_addr = 0, own_lsu = 0, last_lsu = 0;
        bit          g_i, g_l, e_irv, e_lrv, e_mrr, drop_i, drop_l;
        int          beats_total = 0, beats_done = 0;
        int unsigned exp_cnt = 0;
        logic [31:0] e_addr = '0;
        logic [3:0]  e_id = '0;
        logic [7:0]  e_len = '0;
        logic [2:0]  e_size = '0;
        logic [1:0]  e_burst = '0;
        reset_dut();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!ifu_arvalid && ($urandom % 4 == 0)) begin
                ifu_arvalid = 1'b1; ifu_araddr = $urandom;
                ifu_arlen = 4'($urandom_range(0, 7)); ifu_arburst = 2'($urandom_range(0, 2));
            end
            if (!lsu_arvalid && ($urandom % 4 == 0)) begin
                lsu_arvalid = 1'b1; lsu_araddr = $urandom; lsu_arsize = 3'($urandom_range(0, 2));
            end
            m_arready = 1'($urandom);
            m_rdata = $urandom; m_rresp = 2'($urandom); m_rid = 4'($urandom);
            if (busy && !in_addr) begin
                m_rvalid = 1'($urandom); m_rlast = (beats_done == beats_total - 1);
            end else begin
                m_rvalid = ($urandom % 8 == 0); m_rlast = 1'($urandom);
            end
            ifu_rready = ($urandom % 4 != 0);
            lsu_rready = ($urandom % 4 != 0);
            settle();

            g_i = 0; g_l = 0;
            if (!busy) begin
                if (ifu_arvalid && lsu_arvalid) begin g_l = !last_lsu; g_i = last_lsu; end
                else begin g_i = ifu_arvalid; g_l = lsu_arvalid; end
            end
            n_checks++; if (ifu_arready !== g_i || lsu_arready !== g_l) $display("FAIL rnd_grant cyc=%0d got ifu/lsu=%b%b want=%b%b", cyc, ifu_arready, lsu_arready, g_i, g_l); else n_pass++;
            n_checks++; if (m_arvalid !== (busy && in_addr)) $display("FAIL rnd_arvalid cyc=%0d got=%b want=%b", cyc, m_arvalid, busy && in_addr); else n_pass++;
            if (busy && in_addr) begin
                n_checks++;
                if (m_araddr !== e_addr || m_arid !== e_id || m_arlen !== e_len || m_arsize !== e_size || m_arburst !== e_burst)
                    $display("FAIL rnd_ar_fields cyc=%0d got=%h/%h/%h/%h/%h want=%h/%h/%h/%h/%h", cyc, m_araddr, m_arid, m_arlen, m_arsize, m_arburst, e_addr, e_id, e_len, e_size, e_burst);
                else n_pass++;
            end
            e_irv = busy && !in_addr && !own_lsu && m_rvalid;
            e_lrv = busy && !in_addr && own_lsu && m_rvalid;
            e_mrr = busy && !in_addr && (own_lsu ? lsu_rready : ifu_rready);
            n_checks++; if (ifu_rvalid !== e_irv || lsu_rvalid !== e_lrv || m_rready !== e_mrr) $display("FAIL rnd_route cyc=%0d got irv/lrv/rr=%b%b%b want=%b%b%b", cyc, ifu_rvalid, lsu_rvalid, m_rready, e_irv, e_lrv, e_mrr); else n_pass++;
            if (e_irv && ifu_rready) begin
                n_checks++; if (ifu_rdata !== m_rdata || ifu_rresp !== m_rresp || ifu_rlast !== m_rlast) $display("FAIL rnd_ifu_beat cyc=%0d got=%h/%b/%b want=%h/%b/%b", cyc, ifu_rdata, ifu_rresp, ifu_rlast, m_rdata, m_rresp, m_rlast); else n_pass++;
            end
            if (e_lrv && lsu_rready) begin
                n_checks++; if (lsu_rdata !== m_rdata || lsu_rresp !== m_rresp) $display("FAIL rnd_lsu_beat cyc=%0d got=%h/%b want=%h/%b", cyc, lsu_rdata, lsu_rresp, m_rdata, m_rresp); else n_pass++;
            end
            n_checks++; if (contend_cnt !== exp_cnt) $display("FAIL rnd_contend cyc=%0d got=%0d want=%0d", cyc, contend_cnt, exp_cnt); else n_pass++;

            if ((ifu_arvalid && !g_i) || (lsu_arvalid && !g_l)) exp_cnt++;
            if (busy && in_addr) begin
                if (m_arready) begin in_addr = 0; beats_done = 0; end
            end else if (busy && m_rvalid && e_mrr) begin
                beats_done++;
                if (m_rlast) busy = 0;
            end
            drop_i = 0; drop_l = 0;
            if (g_i || g_l) begin
                busy = 1; in_addr = 1; own_lsu = g_l; last_lsu = g_l;
                if (g_l) begin
                    e_addr = lsu_araddr; e_id = 4'h1; e_len = 8'd0; e_size = lsu_arsize; e_burst = 2'b01;
                    beats_total = 1; drop_l = 1;
                end else begin
                    e_addr = ifu_araddr; e_id = 4'h0; e_len = {4'b0000, ifu_arlen}; e_size = 3'b010; e_burst = ifu_arburst;
                    beats_total = int'(ifu_arlen) + 1; drop_i = 1;
                end
            end
            tick();
            if (drop_i) ifu_arvalid = 1'b0;
            if (drop_l) lsu_arvalid = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout after %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_lsu_read();
        test_ifu_burst_stall();
        test_tie_contend();
        test_alternate();
        test_reset_mid_data();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
